counter_20: RTL and testbench
=============================

// Module: counter_20
// PURPOSE
//  Event-driven 5-bit up/down counter with range 0..19, saturating at both ends.
//  Advances one step per rising edge of the 'start' request, sampled on mclk.
//  'ud' selects the count direction; 'state' is the registered count value.
//  Sits between a debounced pushbutton/command source and a display or decoder.
// PARAMETERS
//  WIDTH    5    width of state; must satisfy 2**WIDTH > MAX_VAL
//  MAX_VAL  19   upper count limit (inclusive); lower limit is fixed at 0
// PORTS
//  mclk   in   1      system clock; all logic on rising edge
//  reset  in   1      asynchronous, active-low reset (0 = reset asserted)
//  start  in   1      step request; one count per 0->1 transition, mclk-sampled
//  ud     in   1      direction: 0 = count up, 1 = count down
//  state  out  WIDTH  current count, registered
// BEHAVIOUR
//  - Single clock domain (mclk). start and ud are synchronous inputs and must meet
//    setup/hold to mclk; no internal synchronisers.
//  - reset == 0 forces, immediately and asynchronously: state = 0, start_q = 0.
//  - start_q is a flop holding start from the previous mclk edge.
//  - Step condition at a rising mclk edge: step = start & ~start_q.
//    Holding start high for N cycles produces exactly one step.
//  - With start already 1 at reset release, the first sampled edge counts as a step.
//  - On step with ud = 0: state = (state == MAX_VAL) ? MAX_VAL : state + 1.
//  - On step with ud = 1: state = (state == 0) ? 0 : state - 1.
//  - No step: state holds.
//  - Saturation, not wrap-around: up at 19 stays 19; down at 0 stays 0.
//  - Latency: state updates on the same mclk edge that samples the 0->1 on start.
//    It is visible after that edge; no extra pipeline stage.
//  - ud is sampled only on the step edge; changing ud without a step does nothing.
//  - Out-of-range state (20..31) is unreachable. If it ever occurs, the next step
//    in either direction loads MAX_VAL.
//  - Reset asserted mid-operation overrides everything, including a coincident step.
// TESTING
//  1. Assert reset=0 with state mid-range -> state = 0 at once, with no clock
//     edge required; it stays 0 while reset=0.
//  2. reset=1, ud=0, apply 19 start pulses (each 1 cycle high, 1 cycle low)
//     -> state steps 1,2,...,19, one per pulse.
//  3. At state 19 with ud=0, pulse start -> state stays 19 (saturation).
//  4. Set ud=1, no start -> state holds 19. Then 19 start pulses
//     -> state steps 18,17,...,0.
//  5. At state 0 with ud=1, pulse start -> state stays 0. Hold start high
//     for 5 cycles at state 3, ud=0 -> state becomes 4 only once.
//  6. Assert reset low while a start pulse is active at state 10
//     -> state = 0, and no count occurs on that edge.

Source files
------------

// File: rtl/counter_20.sv
// counter_20: event-driven up/down counter, range 0..MAX_VAL, saturating at both ends.
// One step per mclk-sampled 0->1 transition of 'start'. 'ud' selects direction (0 = up).
// 'reset' is asynchronous and active-low. It clears both the count and the start history.
module counter_20 #(
    parameter int unsigned WIDTH   = 5,
    parameter int unsigned MAX_VAL = 19
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic             start,
    input  logic             ud,
    output logic [WIDTH-1:0] state
);

    localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MAX_VAL);

    logic             r_start_q;
    logic [WIDTH-1:0] r_state;
    logic             w_step;
    logic [WIDTH-1:0] w_next;

    // Rising-edge detect on start and saturating next-count selection
    always_comb begin
        w_step = start & ~r_start_q;
        w_next = r_state;
        if (w_step) begin
            if (r_state > LP_MAX) begin
                // Out-of-range state recovers to the top of range in either direction
                w_next = LP_MAX;
            end else if (!ud) begin
                w_next = (r_state == LP_MAX) ? LP_MAX : r_state + WIDTH'(1);
            end else begin
                w_next = (r_state == '0) ? '0 : r_state - WIDTH'(1);
            end
        end
    end

    // Count and start-history registers, cleared asynchronously by reset
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            r_start_q <= 1'b0;
            r_state   <= '0;
        end else begin
            r_start_q <= start;
            r_state   <= w_next;
        end
    end

    assign state = r_state;

endmodule

// File: tb/tb_counter_20.sv
// Scoreboard bench for counter_20: the driver pushes the expected count for each
// clock edge; an independent monitor pops and compares after every rising edge.
module tb_counter_20;

    localparam int MAXV = 19;

    logic       mclk;
    logic       reset;
    logic       start;
    logic       ud;
    logic [4:0] state;

    int checks   = 0;
    int failures = 0;

    int q[$];
    int m_count  = 0;
    bit m_prev   = 0;

    counter_20 #(.WIDTH(5), .MAX_VAL(19)) dut (
        .mclk  (mclk),
        .reset (reset),
        .start (start),
        .ud    (ud),
        .state (state)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference: a counter with an event count, clamped to [0, MAXV]
    task automatic model_edge(input bit s, input bit d, input bit rn);
        if (!rn) begin
            m_count = 0;
            m_prev  = 0;
        end else begin
            if (s && !m_prev) begin
                if (d) m_count = (m_count - 1 < 0) ? 0 : m_count - 1;
                else   m_count = (m_count + 1 > MAXV) ? MAXV : m_count + 1;
            end
            m_prev = s;
        end
    endtask

    // Drive one cycle of inputs ahead of the next rising edge and queue its expectation
    task automatic cycle(input bit s, input bit d, input bit rn);
        @(negedge mclk);
        start = s;
        ud    = d;
        reset = rn;
        model_edge(s, d, rn);
        q.push_back(m_count);
    endtask

    task automatic pulse(input bit d);
        cycle(1'b1, d, 1'b1);
        cycle(1'b0, d, 1'b1);
    endtask

    // Monitor: state is presented after every rising edge
    initial begin
        forever begin
            @(posedge mclk);
            #1;
            if (q.size() != 0) check("state", int'(state), q.pop_front());
        end
    end

    initial begin
        int budget;
        start = 1'b0;
        ud    = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 check("reset_init", int'(state), 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 1);

        // Reach mid-range, then assert reset between edges
        repeat (7) pulse(1'b0);
        @(posedge mclk);
        #3;
        check("pre_async", int'(state), 7);
        reset = 1'b0;
        #1 check("async_rst", int'(state), 0);
        m_count = 0;
        m_prev  = 0;
        repeat (2) pulse(1'b0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 1);

        // Count up to the top, then saturate
        repeat (19) pulse(1'b0);
        pulse(1'b0);
        pulse(1'b0);

        // Direction change without a step, then count down and saturate at 0
        repeat (3) cycle(0, 1, 1);
        repeat (19) pulse(1'b1);
        pulse(1'b1);
        pulse(1'b1);

        // Held start produces a single step
        repeat (3) pulse(1'b0);
        repeat (5) cycle(1, 0, 1);
        cycle(0, 0, 1);
        cycle(0, 1, 1);

        // Reset coincident with a start pulse at 10
        repeat (6) pulse(1'b0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 1);
        pulse(1'b0);

        // Start already high at reset release counts on the first edge
        cycle(1, 0, 0);
        cycle(1, 0, 1);
        cycle(1, 0, 1);
        cycle(0, 0, 1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 99) < 45),
                  bit'($urandom_range(0, 59) != 0));
        end
        cycle(0, 0, 1);

        budget = 20;
        while (q.size() != 0 && budget > 0) begin
            @(posedge mclk);
            budget--;
        end
        #2;
        check("drain", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
